sys_probe_reader: RTL and testbench

SYS_PROBE_READER -- requirements
Module: sys_probe_reader

---
 rtl/sys_probe_reader.sv | 110 +++++++++++
 tb/tb_sys_probe_reader.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sys_probe_reader.sv
// sys_probe_reader: sweeps the system LED output mux select codes, waits for
// the debug word to settle, captures it and hands it out over valid/ready.
`timescale 1ns/1ps
module sys_probe_reader #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned NUM_SEL       = 8
) (
  input  logic        clk,
  input  logic        SYS_reset,
  input  logic        start,
  output logic [2:0]  SYS_output_sel,
  input  logic [26:0] SYS_leds,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [2:0]  out_sel,
  output logic [26:0] out_data,
  output logic        busy,
  output logic        done
);

  localparam int unsigned SEL_W  = 3;
  localparam int unsigned DATA_W = 27;
  localparam int unsigned CNT_W  = 8;

  localparam logic [SEL_W-1:0] LAST_SEL   = SEL_W'(NUM_SEL - 1);
  localparam logic [CNT_W-1:0] SETTLE_END = CNT_W'(SETTLE_CYCLES);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SET     = 3'd1,
    SETTLE  = 3'd2,
    CAPTURE = 3'd3,
    SEND    = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] settle_cnt;

  // Scan sequencer; SYS_output_sel doubles as the select register and only
  // moves on the edge that enters SET, so it is stable in every other state.
  always_ff @(posedge clk or posedge SYS_reset) begin
    if (SYS_reset) begin
      state          <= IDLE;
      settle_cnt     <= '0;
      SYS_output_sel <= '0;
      out_valid      <= 1'b0;
      out_sel        <= '0;
      out_data       <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            SYS_output_sel <= '0;
            busy           <= 1'b1;
            state          <= SET;
          end
        end

        SET: begin
          settle_cnt <= '0;
          state      <= SETTLE;
        end

        // Leave once the counter reaches SETTLE_CYCLES.
        SETTLE: begin
          if (settle_cnt == SETTLE_END) begin
            state <= CAPTURE;
          end else begin
            settle_cnt <= settle_cnt + CNT_W'(1);
          end
        end

        CAPTURE: begin
          out_data  <= DATA_W'(SYS_leds);
          out_sel   <= SYS_output_sel;
          out_valid <= 1'b1;
          state     <= SEND;
        end

        // Captured word is held until the consumer takes it.
        SEND: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (SYS_output_sel == LAST_SEL) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              SYS_output_sel <= SYS_output_sel + SEL_W'(1);
              state          <= SET;
            end
          end
        end

        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sys_probe_reader.sv
// Testbench for sys_probe_reader: scoreboard of expected words fed by the
// stimulus, checked by an independent monitor on the falling clock edge.
`timescale 1ns/1ps
module tb_sys_probe_reader;

  localparam int unsigned S0 = 4;
  localparam int unsigned N0 = 8;
  localparam int unsigned S1 = 1;
  localparam int unsigned N1 = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        out_ready;
  logic [2:0]  sys_output_sel;
  logic [26:0] sys_leds;
  logic        out_valid;
  logic [2:0]  out_sel;
  logic [26:0] out_data;
  logic        busy;
  logic        done;

  logic        start1;
  logic        ready1;
  logic [2:0]  sel1;
  logic [26:0] leds1;
  logic        valid1;
  logic [2:0]  osel1;
  logic [26:0] odata1;
  logic        busy1;
  logic        done1;

  logic [26:0] tab [8];
  logic [26:0] noise;
  logic [26:0] tab1;

  assign sys_leds = tab[sys_output_sel] ^ noise;
  assign leds1    = tab1 ^ {24'd0, sel1};

  sys_probe_reader #(.SETTLE_CYCLES(S0), .NUM_SEL(N0)) u_dut (
    .clk(clk), .SYS_reset(rst), .start(start), .SYS_output_sel(sys_output_sel),
    .SYS_leds(sys_leds), .out_valid(out_valid), .out_ready(out_ready),
    .out_sel(out_sel), .out_data(out_data), .busy(busy), .done(done)
  );

  sys_probe_reader #(.SETTLE_CYCLES(S1), .NUM_SEL(N1)) u_dut1 (
    .clk(clk), .SYS_reset(rst), .start(start1), .SYS_output_sel(sel1),
    .SYS_leds(leds1), .out_valid(valid1), .out_ready(ready1),
    .out_sel(osel1), .out_data(odata1), .busy(busy1), .done(done1)
  );

  typedef struct packed {
    logic [2:0]  sel;
    logic [26:0] data;
  } word_t;

  word_t sb[$];

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   words = 0;
  int   dones = 0;
  int   rise_exp = 0;
  int   done_exp = 0;
  bit   have_rise = 1'b0;
  bit   have_done = 1'b0;
  logic prev_valid = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on every handshake, checks word latency and done timing.
  always @(negedge clk) begin
    word_t w;
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      if (out_valid && !prev_valid) begin
        chk("valid_rise_edge", cyc, have_rise ? rise_exp : 32'hFFFF_FFFF);
        have_rise = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL word_unexpected: got sel %0d data %0h want no word", out_sel, out_data);
        end else begin
          w = sb.pop_front();
          chk("word_sel", out_sel, w.sel);
          chk("word_data", out_data, w.data);
          if (w.sel != 3'(N0 - 1)) begin
            rise_exp  = cyc + 1 + S0 + 3;
            have_rise = 1'b1;
          end else begin
            done_exp  = cyc + 1;
            have_done = 1'b1;
          end
        end
        words++;
      end
      if (done) begin
        chk("done_edge", cyc, have_done ? done_exp : 32'hFFFF_FFFF);
        have_done = 1'b0;
        dones++;
      end
      prev_valid = out_valid;
    end
  end

  task automatic fill_tab(input bit fixed);
    for (int i = 0; i < 8; i++)
      tab[i] = fixed ? (27'h100_0000 + 27'(i)) : 27'($urandom);
  endtask

  task automatic start_scan();
    word_t w;
    for (int i = 0; i < int'(N0); i++) begin
      w.sel  = 3'(i);
      w.data = tab[i];
      sb.push_back(w);
    end
    @(posedge clk); #1;
    start     = 1'b1;
    rise_exp  = cyc + 1 + S0 + 3;
    have_rise = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic flush_model();
    sb.delete();
    have_rise = 1'b0;
    have_done = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_output_sel"}, sys_output_sel, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_sel"}, out_sel, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  task automatic drive_scan(input bit rand_ready, input int stall_sel,
                            input int repulse_sel, input bit done_start);
    bit stalled  = 1'b0;
    bit repulsed = 1'b0;
    int n = 0;
    while (busy && n < 600) begin
      @(posedge clk); #1;
      n++;
      start     = 1'b0;
      out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (repulse_sel >= 0 && !repulsed && busy && sys_output_sel == 3'(repulse_sel)) begin
        start    = 1'b1;
        repulsed = 1'b1;
      end
      if (done_start && done) start = 1'b1;
      if (stall_sel >= 0 && !stalled && out_valid && out_sel == 3'(stall_sel)) begin
        stalled   = 1'b1;
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
          @(posedge clk); #1;
          n++;
          noise = 27'($urandom);
          chk("stall_valid", out_valid, 1);
          chk("stall_sel", out_sel, stall_sel);
          chk("stall_data", out_data, tab[stall_sel]);
          chk("stall_busy", busy, 1);
        end
        noise     = '0;
        out_ready = 1'b1;
      end
    end
    chk("scan_finished", busy, 0);
    start = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int w0;
    int d0;
    int n;
    int e;

    rst       = 1'b1;
    start     = 1'b0;
    out_ready = 1'b0;
    noise     = '0;
    start1    = 1'b0;
    ready1    = 1'b1;
    tab1      = 27'h2A5_1C3D;
    fill_tab(1'b1);
    #1;
    check_reset_outputs("reset_async");
    #21;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_after_reset_busy", busy, 0);

    // Fixed pattern, ready tied high, start re-pulsed at sel 2 and during DONE.
    out_ready = 1'b1;
    w0 = words;
    d0 = dones;
    start_scan();
    drive_scan(1'b0, -1, 2, 1'b1);
    chk("scanA_words", words - w0, 8);
    chk("scanA_dones", dones - d0, 1);
    chk("scanA_sb_empty", sb.size(), 0);
    repeat (3) @(posedge clk);
    #1;
    chk("scanA_no_restart_busy", busy, 0);
    chk("scanA_no_restart_valid", out_valid, 0);
    chk("scanA_keep_sel", out_sel, 7);
    chk("scanA_keep_data", out_data, 27'h100_0007);

    // Random pattern, random ready, 5-cycle stall at sel 3 with moving SYS_leds.
    fill_tab(1'b0);
    w0 = words;
    start_scan();
    drive_scan(1'b1, 3, -1, 1'b0);
    chk("scanB_words", words - w0, 8);
    chk("scanB_sb_empty", sb.size(), 0);

    // Reset pulse while settling at sel 5.
    fill_tab(1'b0);
    out_ready = 1'b1;
    w0 = words;
    start_scan();
    n = 0;
    while (sys_output_sel != 3'd5 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("scanC_reached_sel5", sys_output_sel, 5);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check_reset_outputs("reset_settle");
    #2;
    rst = 1'b0;
    flush_model();
    chk("scanC_words_before_reset", words - w0, 5);
    repeat (5) @(posedge clk);
    #1;
    chk("scanC_idle_wait", busy, 0);

    // Full scan from sel 0 after the abort.
    fill_tab(1'b0);
    w0 = words;
    start_scan();
    drive_scan(1'b1, -1, -1, 1'b0);
    chk("scanD_words", words - w0, 8);
    chk("scanD_sb_empty", sb.size(), 0);

    // Reset while in SEND with out_ready high: no handshake credited.
    fill_tab(1'b0);
    out_ready = 1'b0;
    start_scan();
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("scanE_in_send", out_valid, 1);
    w0 = words;
    out_ready = 1'b1;
    rst = 1'b1;
    #1;
    check_reset_outputs("reset_send");
    #2;
    rst = 1'b0;
    flush_model();
    repeat (30) @(posedge clk);
    #1;
    chk("scanE_no_credit", words - w0, 0);
    chk("scanE_idle", busy, 0);

    // Single-select, single-cycle-settle instance.
    @(posedge clk); #1;
    start1 = 1'b1;
    e = cyc + 1;
    @(posedge clk); #1;
    start1 = 1'b0;
    n = 0;
    while (!valid1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("small_rise_edge", cyc, e + S1 + 3);
    chk("small_sel", osel1, 0);
    chk("small_data", odata1, 27'h2A5_1C3D);
    chk("small_drive_sel", sel1, 0);
    @(posedge clk); #1;
    chk("small_valid_one_cycle", valid1, 0);
    chk("small_done", done1, 1);
    @(posedge clk); #1;
    chk("small_done_pulse", done1, 0);
    chk("small_idle", busy1, 0);
    chk("small_keep_data", odata1, 27'h2A5_1C3D);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
